// File: rtl/reg_file_mp_if.sv
// Register file bus: write-back write ports, issue-side reads, busy scoreboard control.
interface reg_file_mp_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned NUM_WRITE  = 1
);
  logic [NUM_WRITE-1:0]                 wr_en;
  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wr_data;
  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  rd_addr;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd_data;
  logic [NUM_READ-1:0]                  rd_busy;
  logic                                 alloc_en;
  logic [ADDR_WIDTH-1:0]                alloc_addr;
  logic                                 flush;
  logic                                 wr_conflict;

  // Pipeline side: drives writes, reads and scoreboard control
  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, alloc_en, alloc_addr, flush,
    input  rd_data, rd_busy, wr_conflict
  );

  // Register file side
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, alloc_en, alloc_addr, flush,
    output rd_data, rd_busy, wr_conflict
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with optional write-to-read bypass and busy scoreboard.
module reg_file_mp #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned REG_COUNT   = 32,
  parameter int unsigned NUM_READ    = 2,
  parameter int unsigned NUM_WRITE   = 1,
  parameter bit          BYPASS_EN   = 1'b1,
  parameter bit          ZERO_REG_EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  reg_file_mp_if.slave bus
);
  localparam int unsigned ADDR_WIDTH = $clog2(REG_COUNT);

  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs;
  logic [REG_COUNT-1:0]                 busy;
  logic [REG_COUNT-1:0]                 busy_nxt;
  logic                                 conflict_c;
  logic                                 wr_conflict;

  // True for the hardwired zero register
  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return ZERO_REG_EN && (a == ADDR_WIDTH'(0));
  endfunction

  // Busy next state: write releases, alloc (new producer) wins over write, flush wins over all
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (bus.wr_en[w]) busy_nxt[bus.wr_addr[w]] = 1'b0;
    end
    if (bus.alloc_en && !is_zero(bus.alloc_addr)) busy_nxt[bus.alloc_addr] = 1'b1;
    if (bus.flush) busy_nxt = '0;
  end

  // Detect two or more enabled write ports aimed at the same writable address
  always_comb begin
    conflict_c = 1'b0;
    for (int i = 0; i < NUM_WRITE; i++) begin
      for (int j = i + 1; j < NUM_WRITE; j++) begin
        if (bus.wr_en[i] && bus.wr_en[j] && (bus.wr_addr[i] == bus.wr_addr[j]) &&
            !is_zero(bus.wr_addr[i]))
          conflict_c = 1'b1;
      end
    end
  end

  // Read ports: array lookup, then bypass (highest port wins), then zero/reset override
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      bus.rd_data[r] = regs[bus.rd_addr[r]];
      bus.rd_busy[r] = busy[bus.rd_addr[r]];
      if (BYPASS_EN) begin
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (bus.wr_en[w] && (bus.wr_addr[w] == bus.rd_addr[r])) begin
            bus.rd_data[r] = bus.wr_data[w];
            bus.rd_busy[r] = 1'b0;
          end
        end
      end
      if (is_zero(bus.rd_addr[r]) || !rst_ni) begin
        bus.rd_data[r] = '0;
        bus.rd_busy[r] = 1'b0;
      end
    end
  end

  // Data array: ports applied in index order so the highest-indexed port wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs <= '0;
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (bus.wr_en[w] && !is_zero(bus.wr_addr[w])) regs[bus.wr_addr[w]] <= bus.wr_data[w];
      end
    end
  end

  // Scoreboard and conflict pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      busy        <= busy_nxt;
      wr_conflict <= conflict_c;
    end
  end

  assign bus.wr_conflict = wr_conflict;
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench: dual-write bypass instance (a) and single-write no-bypass instance (b).
module tb_reg_file_mp;
  logic clk;
  logic rst_n;
  int   vec;
  int   err;

  reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .NUM_WRITE(2)) bus_a ();
  reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .NUM_WRITE(1)) bus_b ();

  reg_file_mp #(.DATA_WIDTH(32), .REG_COUNT(32), .NUM_READ(2), .NUM_WRITE(2),
                .BYPASS_EN(1'b1), .ZERO_REG_EN(1'b1))
    u_dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(bus_a));

  reg_file_mp #(.DATA_WIDTH(32), .REG_COUNT(32), .NUM_READ(2), .NUM_WRITE(1),
                .BYPASS_EN(1'b0), .ZERO_REG_EN(1'b1))
    u_dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  bit          ba [32];
  bit          bb [32];
  bit          conf_a_exp;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      ma[i] = '0; mb[i] = '0; ba[i] = 1'b0; bb[i] = 1'b0;
    end
    conf_a_exp = 1'b0;
  endtask

  // Expected read of instance a: stored value, overridden by the last matching write port
  function automatic logic [31:0] exp_data_a(input logic [4:0] a);
    logic [31:0] d;
    d = ma[a];
    for (int p = 0; p < 2; p++)
      if (bus_a.wr_en[p] && bus_a.wr_addr[p] == a) d = bus_a.wr_data[p];
    if (!rst_n || a == 5'd0) d = '0;
    return d;
  endfunction

  function automatic bit exp_busy_a(input logic [4:0] a);
    bit b;
    b = ba[a];
    for (int p = 0; p < 2; p++)
      if (bus_a.wr_en[p] && bus_a.wr_addr[p] == a) b = 1'b0;
    if (!rst_n || a == 5'd0) b = 1'b0;
    return b;
  endfunction

  function automatic logic [31:0] exp_data_b(input logic [4:0] a);
    return (!rst_n || a == 5'd0) ? 32'd0 : mb[a];
  endfunction

  function automatic bit exp_busy_b(input logic [4:0] a);
    return (!rst_n || a == 5'd0) ? 1'b0 : bb[a];
  endfunction

  // One clock edge: model applies writes, releases, allocs and flush from the driven inputs
  task automatic tick();
    conf_a_exp = bus_a.wr_en[0] && bus_a.wr_en[1] &&
                 (bus_a.wr_addr[0] == bus_a.wr_addr[1]) && (bus_a.wr_addr[0] != 5'd0);
    @(posedge clk);
    for (int p = 0; p < 2; p++)
      if (bus_a.wr_en[p]) begin
        if (bus_a.wr_addr[p] != 5'd0) ma[bus_a.wr_addr[p]] = bus_a.wr_data[p];
        ba[bus_a.wr_addr[p]] = 1'b0;
      end
    if (bus_a.alloc_en && bus_a.alloc_addr != 5'd0) ba[bus_a.alloc_addr] = 1'b1;
    if (bus_a.flush) foreach (ba[i]) ba[i] = 1'b0;
    if (bus_b.wr_en[0]) begin
      if (bus_b.wr_addr[0] != 5'd0) mb[bus_b.wr_addr[0]] = bus_b.wr_data[0];
      bb[bus_b.wr_addr[0]] = 1'b0;
    end
    if (bus_b.alloc_en && bus_b.alloc_addr != 5'd0) bb[bus_b.alloc_addr] = 1'b1;
    if (bus_b.flush) foreach (bb[i]) bb[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle();
    bus_a.wr_en = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.rd_addr = '0;
    bus_a.alloc_en = 1'b0; bus_a.alloc_addr = '0; bus_a.flush = 1'b0;
    bus_b.wr_en = '0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.rd_addr = '0;
    bus_b.alloc_en = 1'b0; bus_b.alloc_addr = '0; bus_b.flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    bus_a.wr_en = 2'b11; bus_a.wr_data[0] = 32'h1234_5678; bus_a.wr_data[1] = 32'hCAFE_F00D;
    for (int i = 0; i < 32; i += 2) begin
      bus_a.rd_addr[0] = 5'(i); bus_a.rd_addr[1] = 5'(i + 1);
      bus_a.wr_addr[0] = 5'(i); bus_a.wr_addr[1] = 5'(i + 1);
      bus_b.rd_addr[0] = 5'(i); bus_b.rd_addr[1] = 5'(i + 1);
      #1;
      for (int r = 0; r < 2; r++) begin
        vec++;
        if (bus_a.rd_data[r] !== 32'd0 || bus_a.rd_busy[r] !== 1'b0 ||
            bus_b.rd_data[r] !== 32'd0 || bus_b.rd_busy[r] !== 1'b0) begin
          err++;
          $display("FAIL reset_read addr=%0d port=%0d: a=%h/%b b=%h/%b, required 0/0",
                   i + r, r, bus_a.rd_data[r], bus_a.rd_busy[r], bus_b.rd_data[r], bus_b.rd_busy[r]);
        end
      end
    end
    vec++;
    if (bus_a.wr_conflict !== 1'b0 || bus_b.wr_conflict !== 1'b0) begin
      err++;
      $display("FAIL reset_conflict: a=%b b=%b, required 0", bus_a.wr_conflict, bus_b.wr_conflict);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bypass();
    idle();
    bus_a.wr_en[0] = 1'b1; bus_a.wr_addr[0] = 5'd5; bus_a.wr_data[0] = 32'hDEAD_BEEF;
    bus_a.rd_addr[0] = 5'd5;
    bus_b.wr_en[0] = 1'b1; bus_b.wr_addr[0] = 5'd5; bus_b.wr_data[0] = 32'hDEAD_BEEF;
    bus_b.rd_addr[0] = 5'd5;
    #1;
    vec++;
    if (bus_a.rd_data[0] !== 32'hDEAD_BEEF) begin
      err++; $display("FAIL bypass_same_cycle: got %h, required deadbeef", bus_a.rd_data[0]);
    end
    vec++;
    if (bus_b.rd_data[0] !== 32'd0) begin
      err++; $display("FAIL nobypass_same_cycle: got %h, required 0", bus_b.rd_data[0]);
    end
    tick();
    idle();
    bus_a.rd_addr[1] = 5'd5; bus_b.rd_addr[0] = 5'd5;
    #1;
    vec++;
    if (bus_a.rd_data[1] !== 32'hDEAD_BEEF) begin
      err++; $display("FAIL bypass_next_cycle: got %h, required deadbeef", bus_a.rd_data[1]);
    end
    vec++;
    if (bus_b.rd_data[0] !== 32'hDEAD_BEEF) begin
      err++; $display("FAIL nobypass_next_cycle: got %h, required deadbeef", bus_b.rd_data[0]);
    end
    tick();
  endtask

  task automatic test_conflict();
    idle();
    bus_a.wr_en = 2'b11; bus_a.wr_addr[0] = 5'd7; bus_a.wr_addr[1] = 5'd7;
    bus_a.wr_data[0] = 32'h11; bus_a.wr_data[1] = 32'h22;
    bus_a.rd_addr[0] = 5'd7;
    #1;
    vec++;
    if (bus_a.rd_data[0] !== 32'h22) begin
      err++; $display("FAIL conflict_bypass_prio: got %h, required 22", bus_a.rd_data[0]);
    end
    tick();
    idle();
    bus_a.rd_addr[0] = 5'd7;
    #1;
    vec++;
    if (bus_a.rd_data[0] !== 32'h22) begin
      err++; $display("FAIL conflict_write_prio: got %h, required 22", bus_a.rd_data[0]);
    end
    vec++;
    if (bus_a.wr_conflict !== 1'b1) begin
      err++; $display("FAIL conflict_pulse: got %b, required 1", bus_a.wr_conflict);
    end
    tick();
    vec++;
    if (bus_a.wr_conflict !== 1'b0) begin
      err++; $display("FAIL conflict_pulse_end: got %b, required 0", bus_a.wr_conflict);
    end
    bus_a.wr_en = 2'b11; bus_a.wr_addr[0] = 5'd0; bus_a.wr_addr[1] = 5'd0;
    bus_a.wr_data[0] = 32'h33; bus_a.wr_data[1] = 32'h44;
    bus_a.rd_addr[0] = 5'd0;
    #1;
    vec++;
    if (bus_a.rd_data[0] !== 32'd0) begin
      err++; $display("FAIL zero_bypass: got %h, required 0", bus_a.rd_data[0]);
    end
    tick();
    idle();
    #1;
    vec++;
    if (bus_a.wr_conflict !== 1'b0 || bus_a.rd_data[0] !== 32'd0) begin
      err++;
      $display("FAIL zero_conflict: conflict=%b data=%h, required 0/0", bus_a.wr_conflict, bus_a.rd_data[0]);
    end
    tick();
  endtask

  task automatic test_busy();
    // cycle N: alloc x3
    idle();
    bus_a.alloc_en = 1'b1; bus_a.alloc_addr = 5'd3; bus_a.rd_addr[0] = 5'd3;
    bus_b.alloc_en = 1'b1; bus_b.alloc_addr = 5'd3; bus_b.rd_addr[0] = 5'd3;
    #1;
    vec++;
    if (bus_a.rd_busy[0] !== 1'b0 || bus_b.rd_busy[0] !== 1'b0) begin
      err++; $display("FAIL busy_alloc_cycle: a=%b b=%b, required 0", bus_a.rd_busy[0], bus_b.rd_busy[0]);
    end
    tick();
    // N+1
    idle();
    bus_a.rd_addr[0] = 5'd3; bus_b.rd_addr[0] = 5'd3;
    #1;
    vec++;
    if (bus_a.rd_busy[0] !== 1'b1 || bus_b.rd_busy[0] !== 1'b1) begin
      err++; $display("FAIL busy_after_alloc: a=%b b=%b, required 1", bus_a.rd_busy[0], bus_b.rd_busy[0]);
    end
    tick();
    // N+2: write x3
    bus_a.wr_en[0] = 1'b1; bus_a.wr_addr[0] = 5'd3; bus_a.wr_data[0] = 32'h333;
    bus_b.wr_en[0] = 1'b1; bus_b.wr_addr[0] = 5'd3; bus_b.wr_data[0] = 32'h333;
    #1;
    vec++;
    if (bus_a.rd_busy[0] !== 1'b0) begin
      err++; $display("FAIL busy_release_bypass: got %b, required 0", bus_a.rd_busy[0]);
    end
    vec++;
    if (bus_b.rd_busy[0] !== 1'b1) begin
      err++; $display("FAIL busy_release_nobypass: got %b, required 1", bus_b.rd_busy[0]);
    end
    tick();
    // alloc and write x3 together on a; b shows the delayed release
    idle();
    bus_a.rd_addr[0] = 5'd3; bus_b.rd_addr[0] = 5'd3;
    bus_a.alloc_en = 1'b1; bus_a.alloc_addr = 5'd3;
    bus_a.wr_en[1] = 1'b1; bus_a.wr_addr[1] = 5'd3; bus_a.wr_data[1] = 32'h444;
    #1;
    vec++;
    if (bus_b.rd_busy[0] !== 1'b0) begin
      err++; $display("FAIL busy_release_late: got %b, required 0", bus_b.rd_busy[0]);
    end
    tick();
    idle();
    bus_a.rd_addr[0] = 5'd3;
    #1;
    vec++;
    if (bus_a.rd_busy[0] !== 1'b1 || bus_a.rd_data[0] !== 32'h444) begin
      err++;
      $display("FAIL busy_alloc_wins: busy=%b data=%h, required 1/444", bus_a.rd_busy[0], bus_a.rd_data[0]);
    end
    tick();
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 4; i++) begin
      idle();
      bus_a.alloc_en = 1'b1; bus_a.alloc_addr = 5'(i);
      tick();
    end
    idle();
    bus_a.flush = 1'b1; bus_a.alloc_en = 1'b1; bus_a.alloc_addr = 5'd9;
    tick();
    for (int k = 0; k < 5; k++) begin
      idle();
      bus_a.rd_addr[0] = (k == 4) ? 5'd9 : 5'(k + 1);
      bus_a.rd_addr[1] = 5'd7;
      #1;
      vec++;
      if (bus_a.rd_busy[0] !== 1'b0 || bus_a.rd_data[1] !== 32'h22) begin
        err++;
        $display("FAIL flush addr=%0d: busy=%b x7=%h, required 0/22",
                 bus_a.rd_addr[0], bus_a.rd_busy[0], bus_a.rd_data[1]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int p = 0; p < 2; p++) begin
        bus_a.wr_en[p]   = ($urandom_range(0, 2) == 0);
        bus_a.wr_addr[p] = 5'($urandom_range(0, 7));
        bus_a.wr_data[p] = $urandom;
      end
      for (int r = 0; r < 2; r++)
        bus_a.rd_addr[r] = ($urandom_range(0, 2) == 0) ? bus_a.wr_addr[r] : 5'($urandom_range(0, 7));
      bus_a.alloc_en   = ($urandom_range(0, 3) == 0);
      bus_a.alloc_addr = 5'($urandom_range(0, 7));
      bus_a.flush      = ($urandom_range(0, 31) == 0);
      bus_b.wr_en[0]   = ($urandom_range(0, 2) == 0);
      bus_b.wr_addr[0] = 5'($urandom_range(0, 7));
      bus_b.wr_data[0] = $urandom;
      for (int r = 0; r < 2; r++)
        bus_b.rd_addr[r] = ($urandom_range(0, 2) == 0) ? bus_b.wr_addr[0] : 5'($urandom_range(0, 7));
      bus_b.alloc_en   = ($urandom_range(0, 3) == 0);
      bus_b.alloc_addr = 5'($urandom_range(0, 7));
      bus_b.flush      = ($urandom_range(0, 31) == 0);
      #1;
      for (int r = 0; r < 2; r++) begin
        vec++;
        if (bus_a.rd_data[r] !== exp_data_a(bus_a.rd_addr[r]) ||
            bus_a.rd_busy[r] !== exp_busy_a(bus_a.rd_addr[r])) begin
          err++;
          $display("FAIL rand_a cyc=%0d port=%0d addr=%0d: got %h/%b, required %h/%b", c, r,
                   bus_a.rd_addr[r], bus_a.rd_data[r], bus_a.rd_busy[r],
                   exp_data_a(bus_a.rd_addr[r]), exp_busy_a(bus_a.rd_addr[r]));
        end
        vec++;
        if (bus_b.rd_data[r] !== exp_data_b(bus_b.rd_addr[r]) ||
            bus_b.rd_busy[r] !== exp_busy_b(bus_b.rd_addr[r])) begin
          err++;
          $display("FAIL rand_b cyc=%0d port=%0d addr=%0d: got %h/%b, required %h/%b", c, r,
                   bus_b.rd_addr[r], bus_b.rd_data[r], bus_b.rd_busy[r],
                   exp_data_b(bus_b.rd_addr[r]), exp_busy_b(bus_b.rd_addr[r]));
        end
      end
      tick();
      vec++;
      if (bus_a.wr_conflict !== conf_a_exp || bus_b.wr_conflict !== 1'b0) begin
        err++;
        $display("FAIL rand_conflict cyc=%0d: a=%b b=%b, required %b/0",
                 c, bus_a.wr_conflict, bus_b.wr_conflict, conf_a_exp);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    idle();
    bus_a.wr_en[0] = 1'b1; bus_a.wr_addr[0] = 5'd10; bus_a.wr_data[0] = 32'hA5A5_A5A5;
    bus_a.rd_addr[0] = 5'd10;
    bus_b.wr_en[0] = 1'b1; bus_b.wr_addr[0] = 5'd10; bus_b.wr_data[0] = 32'hA5A5_A5A5;
    bus_b.rd_addr[0] = 5'd10;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vec++;
    if (bus_a.rd_data[0] !== 32'd0 || bus_b.rd_data[0] !== 32'd0) begin
      err++; $display("FAIL rst_mid_immediate: a=%h b=%h, required 0", bus_a.rd_data[0], bus_b.rd_data[0]);
    end
    @(posedge clk);
    #1;
    vec++;
    if (bus_a.rd_data[0] !== 32'd0 || bus_b.rd_data[0] !== 32'd0 || bus_a.rd_busy[0] !== 1'b0) begin
      err++; $display("FAIL rst_mid_held: a=%h b=%h, required 0", bus_a.rd_data[0], bus_b.rd_data[0]);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    bus_a.rd_addr[0] = 5'd10; bus_b.rd_addr[0] = 5'd10;
    bus_a.rd_addr[1] = 5'd7;
    #1;
    vec++;
    if (bus_a.rd_data[0] !== 32'd0 || bus_b.rd_data[0] !== 32'd0 || bus_a.rd_data[1] !== 32'd0) begin
      err++;
      $display("FAIL rst_mid_after: a10=%h b10=%h a7=%h, required 0",
               bus_a.rd_data[0], bus_b.rd_data[0], bus_a.rd_data[1]);
    end
    tick();
  endtask

  initial begin
    vec = 0;
    err = 0;
    rst_n = 1'b0;
    test_reset();
    test_bypass();
    test_conflict();
    test_busy();
    test_flush();
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
